// File: rtl/exe_muldiv_pkg.sv
// exe_muldiv_pkg: shared constants for the RV32M multiply/divide unit.
// Holds the M-extension funct7/funct3 codes, the FSM state encoding and
// small decode helpers used by exe_muldiv.
package exe_muldiv_pkg;

    localparam int RADDR_WIDTH = 5;

    localparam logic [6:0] INST_MULDIV = 7'b0000001;

    localparam logic [2:0] INST_MUL    = 3'b000;
    localparam logic [2:0] INST_MULH   = 3'b001;
    localparam logic [2:0] INST_MULHSU = 3'b010;
    localparam logic [2:0] INST_MULHU  = 3'b011;
    localparam logic [2:0] INST_DIV    = 3'b100;
    localparam logic [2:0] INST_DIVU   = 3'b101;
    localparam logic [2:0] INST_REM    = 3'b110;
    localparam logic [2:0] INST_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    function automatic logic is_muldiv_op(input logic [6:0] funct7);
        return funct7 == INST_MULDIV;
    endfunction

    // rs1 is treated as signed for MULH, MULHSU, DIV, REM
    function automatic logic op_signed_a(input logic [2:0] f3);
        return (f3 == INST_MULH) || (f3 == INST_MULHSU) ||
               (f3 == INST_DIV)  || (f3 == INST_REM);
    endfunction

    // rs2 is treated as signed for MULH, DIV, REM
    function automatic logic op_signed_b(input logic [2:0] f3);
        return (f3 == INST_MULH) || (f3 == INST_DIV) || (f3 == INST_REM);
    endfunction

endpackage

// File: rtl/exe_muldiv_iter.sv
// exe_muldiv_iter: one combinational step of the iterative mul/div datapath.
// Ports: is_div_i selects restoring-divide step vs shift-add step; acc_i is the
//        2*XLEN working accumulator; opb_i the multiplicand/divisor magnitude; acc_o the next accumulator.
//
// Purpose: single shift-add (multiply) or restore-compare-subtract (divide) step.
// Latency: purely combinational.
// Backpressure: none; sequenced entirely by exe_muldiv.
module exe_muldiv_iter #(
    parameter int XLEN = 32
) (
    input  logic                is_div_i,
    input  logic [2*XLEN-1:0]   acc_i,
    input  logic [XLEN-1:0]     opb_i,
    output logic [2*XLEN-1:0]   acc_o
);

    logic [XLEN:0] add_sum;
    logic [XLEN:0] rem_ext;
    logic [XLEN:0] rem_sub;

    always_comb begin
        // Multiply: accumulator is {partial product, remaining multiplier bits};
        // add the multiplicand when the current multiplier LSB is set, then shift right.
        add_sum = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opb_i} : '0);

        // Divide: accumulator is {remainder, dividend/quotient bits}; shift left one
        // bit into the remainder. The partial remainder is always below 2*divisor,
        // so the sign of the XLEN+1 bit difference tells whether the divisor fits.
        rem_ext = acc_i[2*XLEN-1:XLEN-1];
        rem_sub = rem_ext - {1'b0, opb_i};

        acc_o = {add_sum, acc_i[XLEN-1:1]};
        if (is_div_i) begin
            if (!rem_sub[XLEN]) begin
                acc_o = {rem_sub[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
            end else begin
                acc_o = {rem_ext[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/exe_muldiv.sv
// exe_muldiv: iterative RV32M multiply/divide unit beside the execute stage.
// Ports: clk_i/rst_n_i; start_i, funct3_i, op1_i, op2_i, reg_waddr_i launch an op;
//        flush_i cancels it; busy_o, stallreq_o hold the pipeline; valid_o, result_o,
//        reg_waddr_o, reg_we_o deliver the write-back.
// Build option: EXE_MULDIV_FAST_MUL_EN replaces the iterative multiply with a
// single-cycle product (divide stays iterative).
//
// Purpose: RV32M MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU on XLEN-bit operands.
// Latency: XLEN+1 cycles from launch (2 for fast multiply, 1 for div-by-zero/overflow).
// Backpressure: stallreq_o holds the pipeline from launch until the result cycle.
module exe_muldiv
    import exe_muldiv_pkg::*;
#(
    parameter  int XLEN  = 32,
    localparam int CNT_W = $clog2(XLEN) + 1
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    start_i,
    input  logic [2:0]              funct3_i,
    input  logic [XLEN-1:0]         op1_i,
    input  logic [XLEN-1:0]         op2_i,
    input  logic [RADDR_WIDTH-1:0]  reg_waddr_i,
    input  logic                    flush_i,
    output logic                    busy_o,
    output logic                    stallreq_o,
    output logic                    valid_o,
    output logic [XLEN-1:0]         result_o,
    output logic [RADDR_WIDTH-1:0]  reg_waddr_o,
    output logic                    reg_we_o
);

    md_state_e               state_q, state_d;
    logic [CNT_W-1:0]        cnt_q;
    logic [2:0]              f3_q;
    logic [RADDR_WIDTH-1:0]  rd_q;
    logic [2*XLEN-1:0]       acc_q;
    logic [XLEN-1:0]         opb_q;
    logic                    neg_q;
    logic [XLEN-1:0]         result_q;

    logic                    launch;
    logic                    is_div;
    logic                    a_neg, b_neg;
    logic [XLEN-1:0]         mag_a, mag_b;
    logic                    div_zero, div_ovf, special;
    logic [XLEN-1:0]         special_res;
    logic [2*XLEN-1:0]       acc_step, acc_calc, acc_fix;
    logic [XLEN-1:0]         quot, rmd, res_fin;
    logic                    last_step;

    // Reset gates the launch term so stallreq_o is low throughout reset.
    assign launch    = rst_n_i && (state_q == MD_IDLE) && start_i && !flush_i;
    assign is_div    = funct3_i[2];
    assign last_step = (cnt_q == CNT_W'(1));

    // Operand magnitudes and signs; the iteration runs on magnitudes only.
    assign a_neg = op_signed_a(funct3_i) && op1_i[XLEN-1];
    assign b_neg = op_signed_b(funct3_i) && op2_i[XLEN-1];
    assign mag_a = a_neg ? -op1_i : op1_i;
    assign mag_b = b_neg ? -op2_i : op2_i;

    assign div_zero = (op2_i == '0);
    assign div_ovf  = ((funct3_i == INST_DIV) || (funct3_i == INST_REM)) &&
                      (op1_i == {1'b1, {(XLEN-1){1'b0}}}) && (op2_i == '1);
    assign special  = is_div && (div_zero || div_ovf);

    always_comb begin
        special_res = funct3_i[1] ? '0 : op1_i;
        if (div_zero) begin
            special_res = funct3_i[1] ? op1_i : '1;
        end
    end

    exe_muldiv_iter #(.XLEN(XLEN)) u_iter (
        .is_div_i (f3_q[2]),
        .acc_i    (acc_q),
        .opb_i    (opb_q),
        .acc_o    (acc_step)
    );

`ifdef EXE_MULDIV_FAST_MUL_EN
    logic                fast_q;
    logic [2*XLEN-1:0]   fast_a, fast_b, fast_prod;

    // Sign-extend to 2*XLEN so the truncated product is exact for every signedness.
    assign fast_a    = {{XLEN{a_neg}}, op1_i};
    assign fast_b    = {{XLEN{op_signed_b(funct3_i) && op2_i[XLEN-1]}}, op2_i};
    assign fast_prod = fast_a * fast_b;
    assign acc_calc  = fast_q ? acc_q : acc_step;
`else
    assign acc_calc  = acc_step;
`endif

    // Final sign fix: the whole 2*XLEN product for multiplies, each half on its own for divides.
    always_comb begin
        acc_fix = neg_q ? -acc_calc : acc_calc;
        quot    = acc_calc[XLEN-1:0];
        rmd     = acc_calc[2*XLEN-1:XLEN];
        res_fin = '0;
        case (f3_q)
            INST_MUL:                           res_fin = acc_fix[XLEN-1:0];
            INST_MULH, INST_MULHSU, INST_MULHU: res_fin = acc_fix[2*XLEN-1:XLEN];
            INST_DIV, INST_DIVU:                res_fin = neg_q ? -quot : quot;
            INST_REM, INST_REMU:                res_fin = neg_q ? -rmd : rmd;
            default:                            res_fin = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= MD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        busy_o     = (state_q != MD_IDLE);
        stallreq_o = 1'b0;
        valid_o    = 1'b0;
        case (state_q)
            MD_IDLE: begin
                stallreq_o = launch;
                if (launch) begin
                    state_d = special ? MD_DONE : MD_CALC;
                end
            end
            MD_CALC: begin
                stallreq_o = 1'b1;
                if (flush_i) begin
                    state_d = MD_IDLE;
                end else if (last_step) begin
                    state_d = MD_DONE;
                end
            end
            MD_DONE: begin
                valid_o = !flush_i;
                state_d = MD_IDLE;
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q    <= '0;
            f3_q     <= '0;
            rd_q     <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
`ifdef EXE_MULDIV_FAST_MUL_EN
            fast_q   <= 1'b0;
`endif
        end else if (launch) begin
            f3_q  <= funct3_i;
            rd_q  <= reg_waddr_i;
            opb_q <= mag_b;
            acc_q <= {{XLEN{1'b0}}, mag_a};
            // Remainder takes the dividend's sign; everything else the XOR of both.
            neg_q <= (funct3_i[2:1] == 2'b11) ? a_neg : (a_neg ^ b_neg);
            cnt_q <= CNT_W'(XLEN);
            if (special) begin
                result_q <= special_res;
            end
`ifdef EXE_MULDIV_FAST_MUL_EN
            fast_q <= !is_div;
            if (!is_div) begin
                acc_q <= fast_prod;
                neg_q <= 1'b0;
                cnt_q <= CNT_W'(1);
            end
`endif
        end else if (state_q == MD_CALC) begin
            if (flush_i) begin
                cnt_q <= '0;
            end else begin
                acc_q <= acc_calc;
                cnt_q <= cnt_q - CNT_W'(1);
                if (last_step) begin
                    result_q <= res_fin;
                end
            end
        end
    end

    assign result_o    = result_q;
    assign reg_waddr_o = rd_q;
    assign reg_we_o    = valid_o && (rd_q != '0);

endmodule

// File: tb/tb_exe_muldiv.sv
// tb_exe_muldiv: directed-vector bench for exe_muldiv (XLEN = 32).
// Ports: drives every DUT input, checks result value, latency, stall and write-enable.
// Build option: EXE_MULDIV_FAST_MUL_EN shortens the expected multiply latency.
module tb_exe_muldiv;
    import exe_muldiv_pkg::*;

    localparam int XLEN = 32;
`ifdef EXE_MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;
    localparam int SPC_LAT = 1;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    start = 1'b0;
    logic                    flush = 1'b0;
    logic [2:0]              f3 = 3'd0;
    logic [XLEN-1:0]         op1 = '0;
    logic [XLEN-1:0]         op2 = '0;
    logic [RADDR_WIDTH-1:0]  rd = '0;
    logic                    busy_o, stallreq_o, valid_o, reg_we_o;
    logic [XLEN-1:0]         result_o;
    logic [RADDR_WIDTH-1:0]  reg_waddr_o;

    int n_chk   = 0;
    int n_err   = 0;
    int vld_cnt = 0;
    int vld_exp = 0;

    exe_muldiv #(.XLEN(XLEN)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .start_i     (start),
        .funct3_i    (f3),
        .op1_i       (op1),
        .op2_i       (op2),
        .reg_waddr_i (rd),
        .flush_i     (flush),
        .busy_o      (busy_o),
        .stallreq_o  (stallreq_o),
        .valid_o     (valid_o),
        .result_o    (result_o),
        .reg_waddr_o (reg_waddr_o),
        .reg_we_o    (reg_we_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid_o) vld_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Call at (or just after) a falling edge with the unit idle. Launches one op,
    // scrambles the inputs after the launch edge, waits for valid_o and checks it.
    // stray > 0 pulses start_i in that CALC cycle.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] r, input logic [31:0] exp,
                          input int lat, input int stray);
        int   cyc;
        logic stall_bad;
        start = 1'b1; f3 = f; op1 = a; op2 = b; rd = r; flush = 1'b0;
        #1 check({tag, "_stall0"}, 32'(stallreq_o), 32'd1);
        @(posedge clk); #1;
        start = 1'b0;
        op1 = $urandom; op2 = $urandom; f3 = 3'($urandom); rd = 5'($urandom);
        cyc = 0;
        stall_bad = 1'b0;
        while (cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (valid_o) break;
            if (stallreq_o !== 1'b1) stall_bad = 1'b1;
            start = (cyc == stray);
        end
        start = 1'b0;
        check({tag, "_lat"},   32'(cyc), 32'(lat));
        check({tag, "_res"},   result_o, exp);
        check({tag, "_we"},    32'(reg_we_o), 32'(r != 5'd0));
        check({tag, "_waddr"}, 32'(reg_waddr_o), 32'(r));
        check({tag, "_stdn"},  32'(stallreq_o), 32'd0);
        check({tag, "_stcl"},  32'(stall_bad), 32'd0);
        vld_exp++;
        @(negedge clk);
    endtask

    initial begin : main
        logic seen;

        #1;
        check("rst_busy",  32'(busy_o), 32'd0);
        check("rst_stall", 32'(stallreq_o), 32'd0);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_we",    32'(reg_we_o), 32'd0);
        check("rst_res",   result_o, 32'd0);
        check("rst_waddr", 32'(reg_waddr_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("mul",      INST_MUL,    32'd7,          32'hFFFFFFFD, 5'd1, 32'hFFFFFFEB, MUL_LAT, 0);
        run_op("mulh",     INST_MULH,   32'h80000000,   32'h80000000, 5'd2, 32'h40000000, MUL_LAT, 0);
        run_op("mulhsu",   INST_MULHSU, 32'hFFFFFFFF,   32'hFFFFFFFF, 5'd3, 32'hFFFFFFFF, MUL_LAT, 0);
        run_op("mulhu",    INST_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 5'd4, 32'hFFFFFFFE, MUL_LAT, 0);
        run_op("mul_lo0",  INST_MUL,    32'h00010000,   32'h00010000, 5'd5, 32'h00000000, MUL_LAT, 0);
        run_op("mulhu_1",  INST_MULHU,  32'h00010000,   32'h00010000, 5'd6, 32'h00000001, MUL_LAT, 0);
        run_op("div",      INST_DIV,    32'hFFFFFFF9,   32'd2,        5'd7, 32'hFFFFFFFD, DIV_LAT, 0);
        run_op("rem",      INST_REM,    32'hFFFFFFF9,   32'd2,        5'd8, 32'hFFFFFFFF, DIV_LAT, 0);
        run_op("divu",     INST_DIVU,   32'hFFFFFFF9,   32'd2,        5'd9, 32'h7FFFFFFC, DIV_LAT, 0);
        run_op("remu",     INST_REMU,   32'hFFFFFFF9,   32'd2,       5'd10, 32'h00000001, DIV_LAT, 0);
        run_op("div_neg2", INST_DIV,    32'd7,          32'hFFFFFFFE,5'd11, 32'hFFFFFFFD, DIV_LAT, 0);
        run_op("rem_neg2", INST_REM,    32'd7,          32'hFFFFFFFE,5'd12, 32'h00000001, DIV_LAT, 0);
        run_op("remu_7",   INST_REMU,   32'd100,        32'd7,       5'd13, 32'h00000002, DIV_LAT, 0);
        run_op("div0",     INST_DIV,    32'd5,          32'd0,       5'd14, 32'hFFFFFFFF, SPC_LAT, 0);
        run_op("rem0",     INST_REM,    32'd5,          32'd0,       5'd15, 32'h00000005, SPC_LAT, 0);
        run_op("divu0",    INST_DIVU,   32'd5,          32'd0,       5'd16, 32'hFFFFFFFF, SPC_LAT, 0);
        run_op("remu0",    INST_REMU,   32'd5,          32'd0,       5'd17, 32'h00000005, SPC_LAT, 0);
        run_op("div_ovf",  INST_DIV,    32'h80000000,   32'hFFFFFFFF,5'd18, 32'h80000000, SPC_LAT, 0);
        run_op("rem_ovf",  INST_REM,    32'h80000000,   32'hFFFFFFFF,5'd19, 32'h00000000, SPC_LAT, 0);
        run_op("rd_x0",    INST_DIVU,   32'd100,        32'd7,        5'd0, 32'h0000000E, DIV_LAT, 0);
        run_op("stray",    INST_DIV,    32'hFFFFFFF9,   32'd2,       5'd20, 32'hFFFFFFFD, DIV_LAT, 5);

        // Flush a divide in cycle 10, then launch a new op in cycle 11.
        start = 1'b1; f3 = INST_DIV; op1 = 32'd100; op2 = 32'd7; rd = 5'd3;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (valid_o) seen = 1'b1;
        end
        flush = 1'b1;
        #1;
        check("flush_busy10", 32'(busy_o), 32'd1);
        check("flush_vld10",  32'(valid_o), 32'd0);
        check("flush_early",  32'(seen), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_busy11", 32'(busy_o), 32'd0);
        check("flush_vld11",  32'(valid_o), 32'd0);
        run_op("after_flush", INST_DIVU, 32'd100, 32'd7, 5'd3, 32'h0000000E, DIV_LAT, 0);

        // Asynchronous reset in cycle 5 of a divide.
        start = 1'b1; f3 = INST_DIV; op1 = 32'hFFFFFFF9; op2 = 32'd2; rd = 5'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("arst_pre_busy", 32'(busy_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_busy",  32'(busy_o), 32'd0);
        check("arst_stall", 32'(stallreq_o), 32'd0);
        check("arst_valid", 32'(valid_o), 32'd0);
        check("arst_we",    32'(reg_we_o), 32'd0);
        check("arst_res",   result_o, 32'd0);
        check("arst_waddr", 32'(reg_waddr_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("arst_idle", 32'(busy_o), 32'd0);
        run_op("post_rst", INST_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd21, 32'hFFFFFFFE, MUL_LAT, 0);

        check("valid_pulses", 32'(vld_cnt), 32'(vld_exp));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
